row_writer_1_16_256bits: RTL

Write-side counterpart to the 16:1 × 256-bit row selector: accepts 256-bit rows over a valid/ready handshake and assembles them into a registered 4096-bit frame of 16 slots, using the same slot layout so the frame can feed the selector directly. It sits between a row producer (bitmap/sprite loader) and the display path. When all 16 slots are written, it presents a complete frame and holds it until acknowledged.

---
 rtl/row_writer_1_16_256bits.sv | 127 ++++++++++++
 1 files changed

// File: rtl/row_writer_1_16_256bits.sv
// -----------------------------------------------------------------------------
// row_writer_1_16_256bits
//
// Assembles 256-bit rows, received over a valid/ready handshake, into a
// registered 4096-bit frame of 16 slots. The slot layout matches the 16:1 row
// selector, so OUT can feed it directly. Once all 16 slots have been written,
// the frame is presented and held until the consumer acknowledges it.
//
// Ports
//   CLK          in   1     system clock, rising edge
//   RST          in   1     asynchronous, active-high reset
//   CLEAR        in   1     synchronous clear of frame, fill mask and pointer
//   IN           in   256   row data
//   IN_VALID     in   1     row present on IN
//   IN_READY     out  1     block can accept a row (state decode only)
//   AUTO         in   1     1: slot = WPTR, 0: slot = ADDRESS
//   ADDRESS      in   4     target slot when AUTO = 0
//   WPTR         out  4     auto-increment pointer
//   FILLED       out  16    per-slot written mask, bit n = slot n
//   OUT          out  4096  assembled frame, slot n at OUT[4095-256n -: 256]
//   FRAME_VALID  out  1     frame complete (level)
//   FRAME_DONE   out  1     one-cycle pulse in the first complete cycle
//   FRAME_ACK    in   1     consumer has taken the frame
// -----------------------------------------------------------------------------
module row_writer_1_16_256bits (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLEAR,
  input  logic [255:0]  IN,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic          AUTO,
  input  logic [3:0]    ADDRESS,
  output logic [3:0]    WPTR,
  output logic [15:0]   FILLED,
  output logic [4095:0] OUT,
  output logic          FRAME_VALID,
  output logic          FRAME_DONE,
  input  logic          FRAME_ACK
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [3:0]  slot;
  logic [11:0] slot_base;
  logic [15:0] filled_next;
  logic        completes;

  // Handshake is a pure decode of the state so IN_READY never depends on
  // IN_VALID.
  assign IN_READY    = (state == ST_FILL);
  assign FRAME_VALID = (state == ST_FULL);
  assign accept      = IN_VALID && IN_READY;
  assign slot        = AUTO ? WPTR : ADDRESS;

  // Slot n sits at bit offset 256*(15-n); for a 4-bit n, 15-n is simply ~n.
  assign slot_base   = {~slot, 8'd0};

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    filled_next       = FILLED;
    filled_next[slot] = 1'b1;
  end

  assign completes = accept && (filled_next == 16'hFFFF);

  always_comb begin
    state_next = state;
    if (CLEAR) begin
      state_next = ST_FILL;
    end else begin
      unique case (state)
        ST_FILL: if (completes) state_next = ST_FULL;
        ST_FULL: if (FRAME_ACK) state_next = ST_FILL;
        default: state_next = ST_FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change the result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  // The frame store is reset along with the control state: after reset or
  // CLEAR the display path must see an all-zero frame, not stale rows.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT        <= '0;
      FILLED     <= '0;
      WPTR       <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      if (CLEAR) begin
        // Overrides both the accept and the acknowledge of this cycle.
        OUT    <= '0;
        FILLED <= '0;
        WPTR   <= '0;
      end else if (FRAME_VALID && FRAME_ACK) begin
        // OUT is deliberately kept; stale rows remain until overwritten.
        FILLED <= '0;
        WPTR   <= '0;
      end else if (accept) begin
        OUT[slot_base +: 256] <= IN;
        FILLED                <= filled_next;
        if (AUTO) begin
          WPTR <= WPTR + 4'd1;
        end
        FRAME_DONE <= completes;
      end
    end
  end

endmodule
